// File: rtl/banked_buffer_if.sv
// banked_buffer_if: write, read and occupancy signals of the banked buffer, grouped per direction.
interface banked_buffer_if #(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 7,
    parameter int NUM_BANKS = 2
);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    logic                            vsi_inputChipSelect;
    logic [BANK_W-1:0]               vsi_inputBank;
    logic [ADDR_W-1:0]               vsi_inputAddr;
    logic [DATA_W-1:0]               vsi_inputData;
    logic [DATA_W/8-1:0]             vsi_inputByteEn;
    logic                            vsi_outputChipSelect;
    logic [BANK_W-1:0]               vsi_outputBank;
    logic [ADDR_W-1:0]               vsi_outputAddr;
    logic [DATA_W-1:0]               vsi_outputData;
    logic                            vsi_outputValid;
    logic                            vsi_outputHit;
    logic [NUM_BANKS-1:0]            vsi_clearBank;
    logic [NUM_BANKS*(ADDR_W+1)-1:0] vsi_bankCount;
    logic [NUM_BANKS-1:0]            vsi_bankFull;

    modport master (
        output vsi_inputChipSelect, vsi_inputBank, vsi_inputAddr, vsi_inputData, vsi_inputByteEn,
        output vsi_outputChipSelect, vsi_outputBank, vsi_outputAddr, vsi_clearBank,
        input  vsi_outputData, vsi_outputValid, vsi_outputHit, vsi_bankCount, vsi_bankFull
    );
    modport slave (
        input  vsi_inputChipSelect, vsi_inputBank, vsi_inputAddr, vsi_inputData, vsi_inputByteEn,
        input  vsi_outputChipSelect, vsi_outputBank, vsi_outputAddr, vsi_clearBank,
        output vsi_outputData, vsi_outputValid, vsi_outputHit, vsi_bankCount, vsi_bankFull
    );
endinterface

// File: rtl/banked_buffer.sv
// banked_buffer: multi-bank 1W1R store with byte enables, per-entry valid bits,
// per-bank occupancy counters, single-cycle bank clear and 1- or 2-cycle read latency.
module banked_buffer #(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 7,
    parameter int NUM_BANKS = 2,
    parameter int READ_LAT  = 1
) (
    input logic             vsi_clk,
    input logic             vsi_reset_n,
    banked_buffer_if.slave  bus
);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int BYTES  = DATA_W / 8;
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [BANK_W:0] NB = (BANK_W + 1)'(NUM_BANKS);

    if (DATA_W % 8 != 0 || NUM_BANKS < 1 || NUM_BANKS > 16 || (READ_LAT != 1 && READ_LAT != 2)) begin : g_bad_params
        $error("banked_buffer: illegal parameter combination");
    end

    logic [DATA_W-1:0]                mem_q [NUM_BANKS][DEPTH];
    logic [NUM_BANKS-1:0][DEPTH-1:0]  valid_q, valid_d;
    logic [NUM_BANKS-1:0][CNT_W-1:0]  count_q, count_d;
    logic [NUM_BANKS-1:0]             full;
    logic                             wr_en, rd_oob, same, rd_hit;
    logic [DATA_W-1:0]                merged, rd_data;
    logic                             rv1_q, rh1_q;
    logic [DATA_W-1:0]                rd1_q;

    // The merged word serves both the array update and the write-first read bypass.
    always_comb begin
        wr_en  = bus.vsi_inputChipSelect && ({1'b0, bus.vsi_inputBank} < NB);
        rd_oob = {1'b0, bus.vsi_outputBank} >= NB;
        merged = mem_q[bus.vsi_inputBank][bus.vsi_inputAddr];
        for (int i = 0; i < BYTES; i++)
            if (bus.vsi_inputByteEn[i]) merged[8*i +: 8] = bus.vsi_inputData[8*i +: 8];
        same    = wr_en && bus.vsi_outputBank == bus.vsi_inputBank && bus.vsi_outputAddr == bus.vsi_inputAddr;
        rd_hit  = !rd_oob && (same || valid_q[bus.vsi_outputBank][bus.vsi_outputAddr]);
        rd_data = same ? merged : (rd_hit ? mem_q[bus.vsi_outputBank][bus.vsi_outputAddr] : '0);
    end

    // Clear is applied before the write so a same-cycle write survives and is counted.
    always_comb begin
        valid_d = valid_q;
        count_d = count_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bus.vsi_clearBank[b]) begin
                valid_d[b] = '0;
                count_d[b] = '0;
            end
            full[b] = count_q[b] == CNT_W'(DEPTH);
        end
        if (wr_en) begin
            if (!valid_d[bus.vsi_inputBank][bus.vsi_inputAddr])
                count_d[bus.vsi_inputBank] = count_d[bus.vsi_inputBank] + CNT_W'(1);
            valid_d[bus.vsi_inputBank][bus.vsi_inputAddr] = 1'b1;
        end
    end

    always_ff @(posedge vsi_clk)
        if (wr_en) mem_q[bus.vsi_inputBank][bus.vsi_inputAddr] <= merged;

    always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
        if (!vsi_reset_n) begin
            valid_q <= '0;
            count_q <= '0;
            rv1_q   <= 1'b0;
            rh1_q   <= 1'b0;
            rd1_q   <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            rv1_q   <= bus.vsi_outputChipSelect;
            if (bus.vsi_outputChipSelect) begin
                rh1_q <= rd_hit;
                rd1_q <= rd_data;
            end
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic              rv2_q, rh2_q;
        logic [DATA_W-1:0] rd2_q;
        always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
            if (!vsi_reset_n) begin
                rv2_q <= 1'b0;
                rh2_q <= 1'b0;
                rd2_q <= '0;
            end else begin
                rv2_q <= rv1_q;
                if (rv1_q) begin
                    rh2_q <= rh1_q;
                    rd2_q <= rd1_q;
                end
            end
        end
        assign bus.vsi_outputValid = rv2_q;
        assign bus.vsi_outputHit   = rh2_q;
        assign bus.vsi_outputData  = rd2_q;
    end else begin : g_lat1
        assign bus.vsi_outputValid = rv1_q;
        assign bus.vsi_outputHit   = rh1_q;
        assign bus.vsi_outputData  = rd1_q;
    end

    assign bus.vsi_bankCount = count_q;
    assign bus.vsi_bankFull  = full;
endmodule
